io_atr_regs: RTL and testbench

Upstream source of the four 16-bit GPIO output values driven onto the bidirectional daughterboard pins by the pin-level output-enable stage. It holds software-written output registers per bank, written over the serial control bus with a per-bit mask. Each bank also has an auto transmit/receive (ATR) overlay: a four-state machine tracks the TX path's `tx_empty` flag with programmable turn-on and turn-off delays, and selects per-bank TX or RX pin values for the masked bits.

---
 rtl/io_atr_regs.sv | 149 ++++++++++++++
 tb/tb_io_atr_regs.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_atr_regs.sv
// Per-bank GPIO output registers with a masked auto transmit/receive overlay.
// A four-state machine follows tx_empty with programmable turn-on/turn-off delays.
module io_atr_regs #(
   parameter logic [6:0] ADDR_IO_BASE  = 7'd68,
   parameter logic [6:0] ADDR_ATR_BASE = 7'd80,
   parameter int         DELAY_W       = 12
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [6:0]  serial_addr,
   input  logic [31:0] serial_data,
   input  logic        serial_strobe,
   input  logic        tx_empty,
   output logic [15:0] reg_0,
   output logic [15:0] reg_1,
   output logic [15:0] reg_2,
   output logic [15:0] reg_3,
   output logic [1:0]  atr_state
);

   typedef enum logic [1:0] {
      ST_RX       = 2'd0,
      ST_TX_DELAY = 2'd1,
      ST_TX       = 2'd2,
      ST_RX_DELAY = 2'd3
   } atr_state_t;

   logic [15:0]        io_r    [4];
   logic [15:0]        mask_r  [4];
   logic [15:0]        txval_r [4];
   logic [15:0]        rxval_r [4];
   logic [15:0]        pin_nx  [4];
   logic [DELAY_W-1:0] tx_delay_r;
   logic [DELAY_W-1:0] rx_delay_r;
   logic [DELAY_W-1:0] count_r;
   logic [DELAY_W-1:0] count_nx;
   atr_state_t         state_r;
   atr_state_t         state_nx;
   logic               use_tx;

   // Control-bus register file; IO writes merge under the upper-half bit mask.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < 4; k++) begin
            io_r[k]    <= '0;
            mask_r[k]  <= '0;
            txval_r[k] <= '0;
            rxval_r[k] <= '0;
         end
         tx_delay_r <= '0;
         rx_delay_r <= '0;
      end else if (serial_strobe) begin
         for (int k = 0; k < 4; k++) begin
            if (serial_addr == ADDR_IO_BASE + 7'(k))
               io_r[k] <= (io_r[k] & ~serial_data[31:16]) | (serial_data[15:0] & serial_data[31:16]);
            if (serial_addr == ADDR_ATR_BASE + 7'(4 * k))
               mask_r[k] <= serial_data[15:0];
            if (serial_addr == ADDR_ATR_BASE + 7'(4 * k + 1))
               txval_r[k] <= serial_data[15:0];
            if (serial_addr == ADDR_ATR_BASE + 7'(4 * k + 2))
               rxval_r[k] <= serial_data[15:0];
         end
         if (serial_addr == ADDR_ATR_BASE + 7'd16)
            tx_delay_r <= serial_data[DELAY_W-1:0];
         if (serial_addr == ADDR_ATR_BASE + 7'd17)
            rx_delay_r <= serial_data[DELAY_W-1:0];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= ST_RX;
         count_r <= '0;
      end else begin
         state_r <= state_nx;
         count_r <= count_nx;
      end
   end

   // The counter is loaded from the delay register only on entry to a delay
   // state, so rewriting a delay never disturbs a count already running.
   always_comb begin
      state_nx = state_r;
      count_nx = count_r;
      case (state_r)
         ST_RX: begin
            if (!tx_empty) begin
               if (tx_delay_r == '0) begin
                  state_nx = ST_TX;
               end else begin
                  state_nx = ST_TX_DELAY;
                  count_nx = tx_delay_r;
               end
            end
         end
         ST_TX_DELAY: begin
            if (tx_empty)
               state_nx = ST_RX;
            else if (count_r == DELAY_W'(1))
               state_nx = ST_TX;
            else
               count_nx = count_r - DELAY_W'(1);
         end
         ST_TX: begin
            if (tx_empty) begin
               if (rx_delay_r == '0) begin
                  state_nx = ST_RX;
               end else begin
                  state_nx = ST_RX_DELAY;
                  count_nx = rx_delay_r;
               end
            end
         end
         ST_RX_DELAY: begin
            if (!tx_empty)
               state_nx = ST_TX;
            else if (count_r == DELAY_W'(1))
               state_nx = ST_RX;
            else
               count_nx = count_r - DELAY_W'(1);
         end
         default: state_nx = ST_RX;
      endcase
   end

   // TX values stay on the pins until the turn-off delay completes.
   always_comb begin
      use_tx = (state_r == ST_TX) || (state_r == ST_RX_DELAY);
      for (int k = 0; k < 4; k++)
         pin_nx[k] = (io_r[k] & ~mask_r[k]) | ((use_tx ? txval_r[k] : rxval_r[k]) & mask_r[k]);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         reg_0 <= '0;
         reg_1 <= '0;
         reg_2 <= '0;
         reg_3 <= '0;
      end else begin
         reg_0 <= pin_nx[0];
         reg_1 <= pin_nx[1];
         reg_2 <= pin_nx[2];
         reg_3 <= pin_nx[3];
      end
   end

   assign atr_state = state_r;

endmodule

// File: tb/tb_io_atr_regs.sv
// Directed bench for io_atr_regs: IO writes, ATR delays, aborts,
// delay rewrite mid-count and asynchronous reset.
module tb_io_atr_regs;

   logic        clock;
   logic        reset;
   logic [6:0]  serial_addr;
   logic [31:0] serial_data;
   logic        serial_strobe;
   logic        tx_empty;
   logic [15:0] reg_0, reg_1, reg_2, reg_3;
   logic [1:0]  atr_state;

   int vectors;
   int miscompares;

   io_atr_regs dut (
      .clock         (clock),
      .reset         (reset),
      .serial_addr   (serial_addr),
      .serial_data   (serial_data),
      .serial_strobe (serial_strobe),
      .tx_empty      (tx_empty),
      .reg_0         (reg_0),
      .reg_1         (reg_1),
      .reg_2         (reg_2),
      .reg_3         (reg_3),
      .atr_state     (atr_state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic write_reg(input logic [6:0] a, input logic [31:0] d);
      serial_addr   = a;
      serial_data   = d;
      serial_strobe = 1'b1;
      tick();
      serial_strobe = 1'b0;
   endtask

   task automatic test_reset();
      reset         = 1'b1;
      tx_empty      = 1'b1;
      serial_addr   = '0;
      serial_data   = '0;
      serial_strobe = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      vectors++;
      if ({reg_0, reg_1, reg_2, reg_3} !== 64'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_regs: got %h required 0", {reg_0, reg_1, reg_2, reg_3});
      end
      vectors++;
      if (atr_state !== 2'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_state: got %0d required 0", atr_state);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_io_write();
      write_reg(7'd68, 32'hFFFF_A5A5);
      tick();
      vectors++;
      if (reg_0 !== 16'hA5A5) begin
         miscompares++;
         $display("[TB] FAIL io_write0: got %h required a5a5", reg_0);
      end
      write_reg(7'd69, 32'h00F0_0030);
      tick();
      vectors++;
      if (reg_1 !== 16'h0030) begin
         miscompares++;
         $display("[TB] FAIL io_write1: got %h required 0030", reg_1);
      end
      write_reg(7'd68, 32'h000F_0000);
      vectors++;
      if (reg_0 !== 16'hA5A5) begin
         miscompares++;
         $display("[TB] FAIL io_latency: got %h required a5a5", reg_0);
      end
      tick();
      vectors++;
      if (reg_0 !== 16'hA5A0) begin
         miscompares++;
         $display("[TB] FAIL io_masked: got %h required a5a0", reg_0);
      end
      write_reg(7'd100, 32'hFFFF_FFFF);
      write_reg(7'd83, 32'hFFFF_FFFF);
      tick();
      vectors++;
      if ({reg_0, reg_1, reg_2, reg_3} !== {16'hA5A0, 16'h0030, 16'h0, 16'h0}) begin
         miscompares++;
         $display("[TB] FAIL unmapped: got %h required a5a0003000000000", {reg_0, reg_1, reg_2, reg_3});
      end
   endtask

   task automatic test_atr_delay();
      write_reg(7'd80, 32'h0000_00FF);
      write_reg(7'd81, 32'h0000_0011);
      write_reg(7'd82, 32'h0000_0022);
      write_reg(7'd68, 32'hFFFF_AB00);
      write_reg(7'd96, 32'd5);
      tick();
      vectors++;
      if (reg_0 !== 16'hAB22) begin
         miscompares++;
         $display("[TB] FAIL atr_rx_idle: got %h required ab22", reg_0);
      end
      tx_empty = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors++;
         if (atr_state !== 2'd1 || reg_0 !== 16'hAB22) begin
            miscompares++;
            $display("[TB] FAIL atr_txdelay[%0d]: got state %0d reg %h required 1 ab22", i, atr_state, reg_0);
         end
      end
      tick();
      vectors++;
      if (atr_state !== 2'd2 || reg_0 !== 16'hAB22) begin
         miscompares++;
         $display("[TB] FAIL atr_tx_enter: got state %0d reg %h required 2 ab22", atr_state, reg_0);
      end
      tick();
      vectors++;
      if (reg_0 !== 16'hAB11) begin
         miscompares++;
         $display("[TB] FAIL atr_txval: got %h required ab11", reg_0);
      end
   endtask

   task automatic test_zero_delay();
      logic [5:0]  pattern;
      logic [1:0]  prev_state;
      logic [1:0]  exp_state;
      logic [15:0] exp_reg;
      write_reg(7'd96, 32'd0);
      write_reg(7'd97, 32'd0);
      pattern    = 6'b010101;
      prev_state = 2'd2;
      for (int i = 0; i < 6; i++) begin
         tx_empty  = pattern[i];
         tick();
         exp_state = pattern[i] ? 2'd0 : 2'd2;
         exp_reg   = (prev_state == 2'd2) ? 16'hAB11 : 16'hAB22;
         vectors++;
         if (atr_state !== exp_state || reg_0 !== exp_reg) begin
            miscompares++;
            $display("[TB] FAIL zero_delay[%0d]: got state %0d reg %h required %0d %h", i, atr_state, reg_0, exp_state, exp_reg);
         end
         prev_state = exp_state;
      end
   endtask

   task automatic test_rx_abort();
      write_reg(7'd97, 32'd10);
      tick();
      vectors++;
      if (atr_state !== 2'd2 || reg_0 !== 16'hAB11) begin
         miscompares++;
         $display("[TB] FAIL abort_pre: got state %0d reg %h required 2 ab11", atr_state, reg_0);
      end
      tx_empty = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++;
         if (atr_state !== 2'd3 || reg_0 !== 16'hAB11) begin
            miscompares++;
            $display("[TB] FAIL abort_rxdelay[%0d]: got state %0d reg %h required 3 ab11", i, atr_state, reg_0);
         end
      end
      tx_empty = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         vectors++;
         if (atr_state !== 2'd2 || reg_0 !== 16'hAB11) begin
            miscompares++;
            $display("[TB] FAIL abort_tx[%0d]: got state %0d reg %h required 2 ab11", i, atr_state, reg_0);
         end
      end
   endtask

   task automatic test_delay_rewrite();
      write_reg(7'd97, 32'd0);
      write_reg(7'd96, 32'd8);
      tx_empty = 1'b1;
      tick();
      vectors++;
      if (atr_state !== 2'd0) begin
         miscompares++;
         $display("[TB] FAIL rewrite_rx: got %0d required 0", atr_state);
      end
      tx_empty = 1'b0;
      tick();
      tick();
      write_reg(7'd96, 32'd3);
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors++;
         if (atr_state !== 2'd1) begin
            miscompares++;
            $display("[TB] FAIL rewrite_hold[%0d]: got %0d required 1", i, atr_state);
         end
      end
      tick();
      vectors++;
      if (atr_state !== 2'd2) begin
         miscompares++;
         $display("[TB] FAIL rewrite_count8: got %0d required 2", atr_state);
      end
      tx_empty = 1'b1;
      tick();
      tx_empty = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if (atr_state !== 2'd1) begin
            miscompares++;
            $display("[TB] FAIL rewrite_new3[%0d]: got %0d required 1", i, atr_state);
         end
      end
      tick();
      vectors++;
      if (atr_state !== 2'd2) begin
         miscompares++;
         $display("[TB] FAIL rewrite_count3: got %0d required 2", atr_state);
      end
   endtask

   task automatic test_async_reset();
      write_reg(7'd96, 32'd8);
      tx_empty = 1'b1;
      tick();
      tx_empty = 1'b0;
      tick();
      vectors++;
      if (atr_state !== 2'd1 || reg_0 !== 16'hAB22 || reg_1 !== 16'h0030) begin
         miscompares++;
         $display("[TB] FAIL areset_pre: got state %0d reg0 %h reg1 %h required 1 ab22 0030", atr_state, reg_0, reg_1);
      end
      #2 reset = 1'b1;
      #1;
      vectors++;
      if ({reg_0, reg_1, reg_2, reg_3} !== 64'h0 || atr_state !== 2'd0) begin
         miscompares++;
         $display("[TB] FAIL areset_now: got regs %h state %0d required 0 0", {reg_0, reg_1, reg_2, reg_3}, atr_state);
      end
      #2 reset = 1'b0;
      tx_empty = 1'b1;
      tick();
      tick();
      vectors++;
      if (atr_state !== 2'd0 || reg_0 !== 16'h0000) begin
         miscompares++;
         $display("[TB] FAIL areset_after: got state %0d reg %h required 0 0000", atr_state, reg_0);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_io_write();
      test_atr_delay();
      test_zero_delay();
      test_rx_abort();
      test_delay_rewrite();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
